// File: rtl/tpm_pkg.sv
// Shared definitions for the tree-parity-machine field sequencer.
//
// Contents:
//   ACC_W    - width of the signed local-field accumulator
//   POS/NEG  - encodings of +1 / -1 for sigma and tau bits
//   state_t  - sequencer states
package tpm_pkg;

    localparam int ACC_W = 13;

    localparam logic POS = 1'b1;
    localparam logic NEG = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ACC,
        SGN,
        DONE
    } state_t;

endpackage

// File: rtl/tpm_field_acc.sv
// 13-bit signed local-field accumulator.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear to zero (wins over en)
//   en          - accumulate operand this cycle
//   sub         - 1: subtract operand, 0: add operand
//   operand     - WW-bit signed weight, sign-extended internally
//   acc         - current accumulator value (two's complement)
//
// No saturation: the parameter limits of the sequencer keep every
// reachable sum inside the signed ACC_W range.
module tpm_field_acc
    import tpm_pkg::*;
#(
    parameter int WW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             sub,
    input  logic [WW-1:0]    operand,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] operand_ext;

    assign operand_ext = {{(ACC_W - WW){operand[WW-1]}}, operand};

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sub ? (acc - operand_ext) : (acc + operand_ext);
        end
    end

endmodule

// File: rtl/tpm_field_sequencer.sv
// Tree-parity-machine output path sequencer.
//
// For each of K hidden units it streams N weights out of a synchronous
// weight RAM, accumulates +w or -w depending on the matching input bit,
// takes the sign of the local field (zero counts as -1) and finally forms
// tau, the product of all sigmas.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - request one evaluation (taken only when idle)
//   x           - K*N input bits, bit k*N+i; 1 = +1, 0 = -1
//   w_en/w_addr - weight read strobe and address k*N+i
//   w_data      - weight for the address strobed one cycle earlier
//   busy        - evaluation in progress
//   done        - one-cycle pulse; sigma/tau valid from here
//   sigma       - per-unit sign, tau - parity output
//   field       - (only with TPM_FIELD_OUT_EN) final local field of each
//                 unit, unit k at [13k+12:13k]
//
// Optional feature macro: TPM_FIELD_OUT_EN.
module tpm_field_sequencer
    import tpm_pkg::*;
#(
    parameter int K  = 3,
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int AW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [K*N-1:0]   x,
    output logic             w_en,
    output logic [AW-1:0]    w_addr,
    input  logic [WW-1:0]    w_data,
    output logic             busy,
    output logic             done,
    output logic [K-1:0]     sigma,
    output logic             tau
`ifdef TPM_FIELD_OUT_EN
    ,
    output logic [K*ACC_W-1:0] field
`endif
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int XW = (K * N > 1) ? $clog2(K * N) : 1;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [IW-1:0]    i_q, i_d;
    logic [K*N-1:0]   x_q;
    logic [K-1:0]     sigma_work;
    logic [K-1:0]     sigma_next;

    logic             latch_x;
    logic             acc_clr;
    logic             acc_en;
    logic             acc_sub;
    logic             sgn_cap;
    logic [ACC_W-1:0] acc;

    logic [AW-1:0]    base_addr;
    logic [XW-1:0]    x_sel;
    logic             field_pos;
    logic             last_unit;
    logic             last_input;

    assign base_addr  = AW'(k_q) * AW'(N);
    assign x_sel      = XW'(k_q) * XW'(N) + XW'(i_q);
    assign last_unit  = (k_q == KW'(K - 1));
    assign last_input = (i_q == IW'(N - 1));

    // Input bit 0 encodes -1, so the weight is subtracted.
    assign acc_sub    = ~x_q[x_sel];

    // Strictly positive field -> +1; zero or negative -> -1.
    assign field_pos  = ~acc[ACC_W-1] & (|acc);

    tpm_field_acc #(
        .WW (WW)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .sub     (acc_sub),
        .operand (w_data),
        .acc     (acc)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
        end
    end

    // NOTE: every output of this block is given a default before the case
    // so no path leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        w_en    = 1'b0;
        w_addr  = '0;
        latch_x = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        sgn_cap = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    latch_x = 1'b1;
                    k_d     = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                // First read of the unit is issued while the field clears.
                acc_clr = 1'b1;
                w_en    = 1'b1;
                w_addr  = base_addr;
                i_d     = '0;
                state_d = ACC;
            end
            ACC: begin
                // w_data answers the address issued one cycle earlier, so
                // the read for input i+1 overlaps the accumulate of i.
                acc_en = 1'b1;
                if (!last_input) begin
                    w_en   = 1'b1;
                    w_addr = base_addr + AW'(i_q) + AW'(1);
                    i_d    = i_q + IW'(1);
                end else begin
                    state_d = SGN;
                end
            end
            SGN: begin
                sgn_cap = 1'b1;
                if (!last_unit) begin
                    k_d     = k_q + KW'(1);
                    state_d = CLR;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == CLR) || (state_q == ACC) || (state_q == SGN);
    assign done = (state_q == DONE);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        sigma_next      = sigma_work;
        sigma_next[k_q] = field_pos ? POS : NEG;
    end

    // sigma is built in sigma_work and only published with the last unit,
    // so the visible sigma/tau keep the previous result for the whole run.
    // tau is +1 when the number of -1 units is even (product of signs).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            sigma_work <= '0;
            sigma      <= '0;
            tau        <= 1'b0;
        end else begin
            if (latch_x) begin
                x_q <= x;
            end
            if (sgn_cap) begin
                sigma_work <= sigma_next;
                if (last_unit) begin
                    sigma <= sigma_next;
                    tau   <= ~(^(~sigma_next));
                end
            end
        end
    end

`ifdef TPM_FIELD_OUT_EN
    logic [K*ACC_W-1:0] field_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q <= '0;
        end else if (sgn_cap) begin
            for (int u = 0; u < K; u++) begin
                if (k_q == KW'(u)) begin
                    field_q[u*ACC_W +: ACC_W] <= acc;
                end
            end
        end
    end

    assign field = field_q;
`endif

endmodule

// File: tb/tb_tpm_field_sequencer.sv
// Self-checking bench for tpm_field_sequencer: directed cases plus
// randomized weights/inputs compared against a sum-of-products model.
module tb_tpm_field_sequencer;

    localparam int K   = 3;
    localparam int N   = 4;
    localparam int WW  = 4;
    localparam int AW  = 8;
    localparam int XN  = K * N;
    localparam int FW  = 13;
    localparam int PER = N + 2;
    localparam int LAT = K * PER + 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [XN-1:0]   x;
    logic            w_en;
    logic [AW-1:0]   w_addr;
    logic [WW-1:0]   w_data;
    logic            busy;
    logic            done;
    logic [K-1:0]    sigma;
    logic            tau;
`ifdef TPM_FIELD_OUT_EN
    logic [K*FW-1:0] field;
`endif

    logic [WW-1:0]   wmem [XN];

    int n_checks = 0;
    int n_fail   = 0;

    logic [K-1:0]    prev_sigma;
    logic            prev_tau;

    tpm_field_sequencer #(
        .K  (K),
        .N  (N),
        .WW (WW),
        .AW (AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
        .w_en   (w_en),
        .w_addr (w_addr),
        .w_data (w_data),
        .busy   (busy),
        .done   (done),
        .sigma  (sigma),
        .tau    (tau)
`ifdef TPM_FIELD_OUT_EN
        ,
        .field  (field)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight RAM with one cycle read latency.
    always @(posedge clk) begin
        if (w_en) w_data <= wmem[w_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Local field of unit k = sum over i of (+w or -w); sigma = field > 0;
    // tau = +1 when the count of -1 units is even.
    function automatic void model(input logic [XN-1:0] xv, output logic [K-1:0] s,
                                  output logic t, output logic [K*FW-1:0] f);
        int zeros;
        zeros = 0;
        for (int k = 0; k < K; k++) begin
            int sum;
            sum = 0;
            for (int i = 0; i < N; i++) begin
                int w;
                w = int'($signed(wmem[k*N + i]));
                sum = xv[k*N + i] ? sum + w : sum - w;
            end
            s[k] = (sum > 0);
            f[k*FW +: FW] = FW'(sum);
            if (sum <= 0) zeros++;
        end
        t = (zeros % 2 == 0);
    endfunction

    task automatic fill_weights(input logic [WW-1:0] w);
        for (int j = 0; j < XN; j++) wmem[j] = w;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"},   64'(busy),   64'(0));
        check({tag, " done"},   64'(done),   64'(0));
        check({tag, " w_en"},   64'(w_en),   64'(0));
        check({tag, " w_addr"}, 64'(w_addr), 64'(0));
        check({tag, " sigma"},  64'(sigma),  64'(0));
        check({tag, " tau"},    64'(tau),    64'(0));
    endtask

    // One evaluation: accept, watch the read sequence cycle by cycle,
    // then compare latency and results against the model.
    task automatic run_eval(input logic [XN-1:0] xv, input string tag,
                            output logic [K-1:0] s_obs, output logic t_obs);
        logic [K-1:0]    es;
        logic            et;
        logic [K*FW-1:0] ef;
        int              lat;
        model(xv, es, et, ef);
        @(negedge clk);
        x     = xv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x     = XN'($urandom);
        lat   = 0;
        for (int c = 1; c <= 2 * LAT; c++) begin
            if (c > 1) @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (c < LAT) begin
                int p;
                p = (c - 1) % PER;
                check({tag, " busy"}, 64'(busy), 64'(1));
                check({tag, " w_en"}, 64'(w_en), 64'(p < N));
                if (p < N)
                    check({tag, " w_addr"}, 64'(w_addr), 64'(((c - 1) / PER) * N + p));
                if (c == N + 3) begin
                    check({tag, " sigma held"}, 64'(sigma), 64'(prev_sigma));
                    check({tag, " tau held"},   64'(tau),   64'(prev_tau));
                end
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " busy@done"}, 64'(busy), 64'(0));
        check({tag, " sigma"}, 64'(sigma), 64'(es));
        check({tag, " tau"},   64'(tau),   64'(et));
`ifdef TPM_FIELD_OUT_EN
        check({tag, " field"}, 64'(field), 64'(ef));
`endif
        s_obs      = sigma;
        t_obs      = tau;
        prev_sigma = es;
        prev_tau   = et;
    endtask

    initial begin
        logic [K-1:0]    s;
        logic            t;
        logic [K-1:0]    es1, es2;
        logic            et1, et2;
        logic [K*FW-1:0] ef;
        logic [XN-1:0]   xa, xb;
        int              ndone, first_c, second_c;

        rst_n      = 1'b0;
        start      = 1'b0;
        x          = '0;
        prev_sigma = '0;
        prev_tau   = 1'b0;
        fill_weights(4'h1);

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // All weights +1, all inputs +1.
        run_eval({XN{1'b1}}, "all_pos", s, t);
        check("all_pos sigma const", 64'(s), 64'(3'b111));
        check("all_pos tau const",   64'(t), 64'(1));

        // Unit 0 sums to exactly zero, which must count as -1.
        wmem[0] = 4'h3; wmem[1] = 4'hE; wmem[2] = 4'h1; wmem[3] = 4'h0;
        run_eval({{(XN-4){1'b1}}, 4'b1011}, "zero_field", s, t);
        check("zero_field sigma const", 64'(s), 64'(3'b110));
        check("zero_field tau const",   64'(t), 64'(0));

        // Most negative reachable fields.
        fill_weights(4'h9);
        run_eval({XN{1'b1}}, "all_neg", s, t);
        check("all_neg sigma const", 64'(s), 64'(3'b000));
        check("all_neg tau const",   64'(t), 64'(0));
`ifdef TPM_FIELD_OUT_EN
        check("all_neg field const", 64'(field), 64'({3{13'h1FE4}}));
`endif

        // start held for 40 cycles: two back-to-back runs, x edits mid-run.
        for (int j = 0; j < XN; j++) wmem[j] = WW'($urandom);
        xa = XN'($urandom);
        xb = XN'($urandom);
        model(xa, es1, et1, ef);
        model(xb, es2, et2, ef);
        @(negedge clk);
        x        = xa;
        start    = 1'b1;
        ndone    = 0;
        first_c  = 0;
        second_c = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 5)  x = xb;
            if (c == 25) x = XN'($urandom);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_c = c;
                    check("hold run1 sigma", 64'(sigma), 64'(es1));
                    check("hold run1 tau",   64'(tau),   64'(et1));
                end else begin
                    second_c = c;
                    check("hold run2 sigma", 64'(sigma), 64'(es2));
                    check("hold run2 tau",   64'(tau),   64'(et2));
                end
            end
        end
        start = 1'b0;
        check("hold done count",   64'(ndone),             64'(2));
        check("hold first done",   64'(first_c),           64'(LAT));
        check("hold done spacing", 64'(second_c - first_c), 64'(LAT + 1));
        repeat (3) @(negedge clk);
        check("hold idle busy", 64'(busy), 64'(0));
        prev_sigma = es2;
        prev_tau   = et2;

        // Asynchronous reset in the middle of unit 1 accumulation.
        @(negedge clk);
        x     = XN'($urandom);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrun reset");
        @(negedge clk);
        rst_n      = 1'b1;
        prev_sigma = '0;
        prev_tau   = 1'b0;
        run_eval(XN'($urandom), "after_reset", s, t);

        // Randomized weights and inputs.
        for (int r = 0; r < 12; r++) begin
            for (int j = 0; j < XN; j++) wmem[j] = WW'($urandom);
            run_eval(XN'($urandom), $sformatf("rand%0d", r), s, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
